reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter AW, default 3, register-file address width; depth N = 2**AW.
REQ-002 Parameter DW, default 8, data width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 first_addr  input  AW  first register to dump; sampled with start.
REQ-007 last_addr  input  AW  final register to dump; sampled with start.
REQ-008 abort  input  1  synchronous cancel of a dump in progress.
REQ-009 rd_addr  output  AW  read address to the register file; always equals the internal pointer ptr.
REQ-010 rd_data  input  DW  combinational read data returned for rd_addr in the same cycle.
REQ-011 out_valid  output  1  out_data/out_addr/out_last hold a valid beat.
REQ-012 out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both high at posedge.
REQ-013 out_data  output  DW  captured register contents.
REQ-014 out_addr  output  AW  address out_data was read from.
REQ-015 out_last  output  1  beat is the one for last_addr.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-018 States: IDLE, FETCH, SEND, DONE; all outputs are registered except rd_addr, which is driven directly from ptr.
REQ-019 IDLE: on start=1, ptr<=first_addr, last_q<=last_addr, next state FETCH; start=0 holds IDLE.
REQ-020 FETCH (one cycle): out_data<=rd_data, out_addr<=ptr, out_last<=(ptr==last_q), out_valid<=1, ptr<=ptr+1 mod N, next state SEND.
REQ-021 SEND, no handshake: all out_* outputs and ptr hold, regardless of out_ready history.
REQ-022 SEND, handshake with out_last=0: the next beat loads the same cycle per REQ-020 (out_valid stays 1), giving one beat per cycle under continuous out_ready.
REQ-023 SEND, handshake with out_last=1: out_valid<=0, next state DONE.
REQ-024 DONE: done=1 for exactly this cycle, next state IDLE; start is ignored in DONE.
REQ-025 Beat count = ((last_addr - first_addr) mod N) + 1; first_addr==last_addr yields one beat; last_addr<first_addr wraps through N-1 to 0.
REQ-026 start while busy is ignored; first_addr and last_addr changes after capture have no effect.
REQ-027 rd_data is sampled at the capturing edge, so register-file writes before that edge are visible in the dump and writes after it are not.
REQ-028 abort=1 in FETCH, SEND, or DONE: next state IDLE, out_valid<=0, done stays 0; abort takes priority over a simultaneous handshake, and abort in IDLE has no effect.
REQ-029 First out_valid rises 2 cycles after the start edge (IDLE->FETCH->SEND).

Reset
REQ-030 reset=1 forces IDLE asynchronously: out_valid=0, out_last=0, done=0, busy=0, out_data=0, out_addr=0, ptr=0 (so rd_addr=0), last_q=0.
REQ-031 Reset asserted mid-dump discards the dump with no done pulse; after release the block waits in IDLE for a new start.

Verification
REQ-032 Reg file holds core[i]=8'h10+i; start with first=0, last=7, out_ready=1 -> 8 consecutive beats with out_addr 0..7, out_data 8'h10..8'h17, out_last only on addr 7, then done pulses for one cycle.
REQ-033 first=6, last=1 -> beats at addresses 6,7,0,1 (4 beats), out_last on addr 1.
REQ-034 first=last=3, with out_ready held 0 for 5 cycles then 1 -> out_valid held with out_addr 3 stable throughout the stall, single beat with out_last=1, then done.
REQ-035 Toggle out_ready 1/0 each cycle with first=0, last=3 -> no beat duplicated or lost, and data matches core[] at each capture edge.
REQ-036 abort in SEND after 2 beats -> out_valid=0 next cycle, no done, busy=0, and a new start then dumps correctly.
REQ-037 Assert reset during SEND -> all outputs reach their reset values immediately without a clock edge, and a start pulsed while busy in a separate run is ignored.

Source files
------------

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - streams a wrapping range of register-file entries out as valid/ready beats
module reg_dump #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] last_q;
    logic          capture;

    assign rd_addr = ptr;

    // A beat is loaded on entry to SEND and again on every non-final handshake,
    // so continuous out_ready yields one beat per cycle.
    always_comb begin
        capture = 1'b0;
        if (!abort) begin
            if (state == FETCH)
                capture = 1'b1;
            else if (state == SEND && out_ready && !out_last)
                capture = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (capture) begin
                out_data  <= rd_data;
                out_addr  <= ptr;
                out_last  <= (ptr == last_q);
                out_valid <= 1'b1;
                ptr       <= ptr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr    <= first_addr;
                        last_q <= last_addr;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    // abort wins over a handshake landing on the same edge
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready && out_last) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - directed self-checking bench for reg_dump
module tb_reg_dump;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] first_addr;
    logic [2:0] last_addr;
    logic       abort;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] core [8];
    int checks;
    int failures;

    assign rd_data = core[rd_addr];

    reg_dump #(.AW(3), .DW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .first_addr(first_addr),
        .last_addr(last_addr), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic init_core();
        for (int i = 0; i < 8; i++) core[i] = 8'h10 + 8'(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int a;
        logic hs;
        checks = 0;
        failures = 0;
        init_core();
        reset = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
        abort = 1'b0; out_ready = 1'b0;

        // reset state
        #12;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        tick();
        reset = 1'b0;
        tick();

        // full dump 0..7 with continuous ready
        out_ready = 1'b1; first_addr = 3'd0; last_addr = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check("a_busy_fetch", 32'(busy), 1);
        check("a_valid_fetch", 32'(out_valid), 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("a_valid", 32'(out_valid), 1);
            check("a_addr", 32'(out_addr), 32'(i));
            check("a_data", 32'(out_data), 32'h10 + 32'(i));
            check("a_last", 32'(out_last), (i == 7) ? 1 : 0);
            tick();
        end
        check("a_done", 32'(done), 1);
        check("a_valid_off", 32'(out_valid), 0);
        tick();
        check("a_done_pulse", 32'(done), 0);
        check("a_busy_idle", 32'(busy), 0);

        // wrapping range 6,7,0,1
        first_addr = 3'd6; last_addr = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            a = (6 + i) % 8;
            check("b_addr", 32'(out_addr), 32'(a));
            check("b_data", 32'(out_data), 32'h10 + 32'(a));
            check("b_last", 32'(out_last), (i == 3) ? 1 : 0);
            tick();
        end
        check("b_done", 32'(done), 1);
        tick();

        // single beat with a 5-cycle stall
        out_ready = 1'b0; first_addr = 3'd3; last_addr = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("c_valid_stall", 32'(out_valid), 1);
            check("c_addr_stall", 32'(out_addr), 3);
            check("c_last_stall", 32'(out_last), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("c_done", 32'(done), 1);
        check("c_valid_off", 32'(out_valid), 0);
        tick();

        // toggled ready; core[3] written before its capture, core[1] after
        core[3] = 8'h33;
        first_addr = 3'd0; last_addr = 3'd3; start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        k = 0;
        for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
            if (out_valid) begin
                check("d_addr", 32'(out_addr), 32'(k));
                check("d_data", 32'(out_data), (k == 3) ? 32'h33 : 32'h10 + 32'(k));
                check("d_last", 32'(out_last), (k == 3) ? 1 : 0);
                if (out_addr == 3'd1) core[1] = 8'hEE;
            end
            out_ready = ~out_ready;
            hs = out_valid && out_ready;
            tick();
            if (hs) k++;
        end
        check("d_beats", 32'(k), 4);
        check("d_done", 32'(done), 1);
        tick();
        init_core();

        // abort after two accepted beats, with ready high on the abort edge
        out_ready = 1'b1; first_addr = 3'd0; last_addr = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("e_addr_pre", 32'(out_addr), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("e_valid", 32'(out_valid), 0);
        check("e_busy", 32'(busy), 0);
        check("e_done", 32'(done), 0);
        tick();
        check("e_done_later", 32'(done), 0);
        first_addr = 3'd2; last_addr = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("e2_addr0", 32'(out_addr), 2);
        check("e2_data0", 32'(out_data), 32'h12);
        tick();
        check("e2_addr1", 32'(out_addr), 3);
        check("e2_last1", 32'(out_last), 1);
        tick();
        check("e2_done", 32'(done), 1);
        tick();

        // asynchronous reset in SEND
        out_ready = 1'b0; first_addr = 3'd5; last_addr = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("f_valid_pre", 32'(out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("f_valid", 32'(out_valid), 0);
        check("f_busy", 32'(busy), 0);
        check("f_data", 32'(out_data), 0);
        check("f_addr", 32'(out_addr), 0);
        check("f_rd_addr", 32'(rd_addr), 0);
        check("f_last", 32'(out_last), 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("f_done_after", 32'(done), 0);
        check("f_busy_after", 32'(busy), 0);

        // start while busy is ignored
        first_addr = 3'd4; last_addr = 3'd5; start = 1'b1;
        tick();
        first_addr = 3'd0; last_addr = 3'd0;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        check("g_addr0", 32'(out_addr), 4);
        check("g_data0", 32'(out_data), 32'h14);
        tick();
        check("g_addr1", 32'(out_addr), 5);
        check("g_last1", 32'(out_last), 1);
        tick();
        check("g_done", 32'(done), 1);
        tick();
        check("g_busy_end", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
